// File: rtl/cond_unit_pipe.sv
// cond_unit_pipe: ARM condition check against banked NZCV flags, gated E->M enables,
// and saturating executed/skipped instruction counters.
module cond_unit_pipe #(
    parameter int NCTX  = 1,
    parameter int CNT_W = 16,
    parameter int CW    = (NCTX > 1) ? $clog2(NCTX) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_e,
    input  logic [CW-1:0]    ctx_e,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flagw_e,
    input  logic             regw_e,
    input  logic             memw_e,
    input  logic             pcs_e,
    input  logic             branch_e,
    input  logic [3:0]       aluflags_e,
    input  logic             stall,
    input  logic             flush_e,
    input  logic             clr_cnt,
    output logic             condex_e,
    output logic [3:0]       flags_e,
    output logic             regwrite_m,
    output logic             memwrite_m,
    output logic             pcsrc_m,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);
    logic [3:0]       r_flags [NCTX];
    logic             r_regw, r_memw, r_pcs;
    logic [CNT_W-1:0] r_exec, r_skip;
    logic [3:0]       w_flags;
    logic             w_base, w_condex, w_live, w_fire;
    logic             w_n, w_z, w_c, w_v;

    // Out-of-range contexts match nothing, so they read as all-zero flags.
    always_comb begin
        w_flags = '0;
        for (int c = 0; c < NCTX; c++)
            if (ctx_e == CW'(c)) w_flags = r_flags[c];
    end

    assign {w_n, w_z, w_c, w_v} = w_flags;

    // Odd codes invert their even partner; 111x is AL/NV.
    always_comb begin
        w_base = 1'b1;
        case (cond_e[3:1])
            3'b000:  w_base = w_z;
            3'b001:  w_base = w_c;
            3'b010:  w_base = w_n;
            3'b011:  w_base = w_v;
            3'b100:  w_base = w_c & ~w_z;
            3'b101:  w_base = w_n == w_v;
            3'b110:  w_base = ~w_z & (w_n == w_v);
            default: w_base = ~cond_e[0];
        endcase
        w_condex = (cond_e[3:1] == 3'b111) ? w_base : w_base ^ cond_e[0];
    end

    assign w_live = valid_e & ~flush_e & ~stall;
    assign w_fire = w_live & w_condex;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCTX; c++) r_flags[c] <= '0;
            r_regw <= 1'b0;
            r_memw <= 1'b0;
            r_pcs  <= 1'b0;
            r_exec <= '0;
            r_skip <= '0;
        end else begin
            if (!stall) begin
                r_regw <= w_fire & regw_e;
                r_memw <= w_fire & memw_e;
                r_pcs  <= w_fire & (pcs_e | branch_e);
            end
            for (int c = 0; c < NCTX; c++) begin
                if (w_fire && ctx_e == CW'(c)) begin
                    if (flagw_e[1]) r_flags[c][3:2] <= aluflags_e[3:2];
                    if (flagw_e[0]) r_flags[c][1:0] <= aluflags_e[1:0];
                end
            end
            if (clr_cnt) begin
                r_exec <= '0;
                r_skip <= '0;
            end else if (w_live) begin
                if (w_condex && !(&r_exec)) r_exec <= r_exec + CNT_W'(1);
                if (!w_condex && !(&r_skip)) r_skip <= r_skip + CNT_W'(1);
            end
        end
    end

    assign condex_e   = w_condex;
    assign flags_e    = w_flags;
    assign regwrite_m = r_regw;
    assign memwrite_m = r_memw;
    assign pcsrc_m    = r_pcs;
    assign exec_cnt   = r_exec;
    assign skip_cnt   = r_skip;
endmodule

// File: tb/tb_cond_unit_pipe.sv
// tb_cond_unit_pipe: scoreboard bench for cond_unit_pipe with three flag contexts
// (plus one out-of-range select value) and 4-bit counters.
module tb_cond_unit_pipe;
    localparam int NCTX = 3;
    localparam int CNT_W = 4;
    localparam int CW = 2;

    logic clk = 1'b0, reset = 1'b0;
    logic valid_e = 0, regw_e = 0, memw_e = 0, pcs_e = 0, branch_e = 0;
    logic stall = 0, flush_e = 0, clr_cnt = 0;
    logic [CW-1:0] ctx_e = '0;
    logic [3:0] cond_e = '0, aluflags_e = '0;
    logic [1:0] flagw_e = '0;
    logic condex_e, regwrite_m, memwrite_m, pcsrc_m;
    logic [3:0] flags_e;
    logic [CNT_W-1:0] exec_cnt, skip_cnt;

    cond_unit_pipe #(.NCTX(NCTX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .ctx_e(ctx_e), .cond_e(cond_e),
        .flagw_e(flagw_e), .regw_e(regw_e), .memw_e(memw_e), .pcs_e(pcs_e),
        .branch_e(branch_e), .aluflags_e(aluflags_e), .stall(stall), .flush_e(flush_e),
        .clr_cnt(clr_cnt), .condex_e(condex_e), .flags_e(flags_e),
        .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .pcsrc_m(pcsrc_m),
        .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic cx; logic [3:0] f; } pre_t;
    typedef struct { logic r, m, p; logic [3:0] e, s; } post_t;
    pre_t  q_pre[$];
    post_t q_post[$];

    int n_chk = 0, n_err = 0;
    logic [3:0] mf [NCTX];
    logic mr = 0, mm = 0, mp = 0;
    logic [3:0] me = 0, ms = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && n == v;
            4'd13: return z || n != v;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one E slot at a falling edge, predict, then wait for the next falling edge.
    task automatic cyc(input logic v, input logic [CW-1:0] cx, input logic [3:0] cd,
                       input logic [1:0] fw, input logic rw, mw, ps, br,
                       input logic [3:0] al, input logic st, fl, cl);
        logic [3:0] fz;
        logic ok, live;
        valid_e = v; ctx_e = cx; cond_e = cd; flagw_e = fw; regw_e = rw; memw_e = mw;
        pcs_e = ps; branch_e = br; aluflags_e = al; stall = st; flush_e = fl; clr_cnt = cl;
        fz = (cx < NCTX) ? mf[cx] : 4'b0000;
        ok = cond_ok(cd, fz);
        live = v && !fl && !st;
        q_pre.push_back('{ok, fz});
        if (!st) begin
            mr = live && ok && rw;
            mm = live && ok && mw;
            mp = live && ok && (ps || br);
        end
        if (live && ok && cx < NCTX) begin
            if (fw[1]) mf[cx][3:2] = al[3:2];
            if (fw[0]) mf[cx][1:0] = al[1:0];
        end
        if (cl) begin
            me = 0; ms = 0;
        end else if (live) begin
            if (ok && me != 4'hf) me = me + 1;
            if (!ok && ms != 4'hf) ms = ms + 1;
        end
        q_post.push_back('{mr, mm, mp, me, ms});
        @(negedge clk);
    endtask

    initial forever begin
        pre_t p;
        @(negedge clk);
        #2;
        if (q_pre.size() > 0) begin
            p = q_pre.pop_front();
            chk("condex_e", {7'b0, condex_e}, {7'b0, p.cx});
            chk("flags_e", {4'b0, flags_e}, {4'b0, p.f});
        end
    end

    initial forever begin
        post_t p;
        @(posedge clk);
        #1;
        if (q_post.size() > 0) begin
            p = q_post.pop_front();
            chk("m_out", {5'b0, regwrite_m, memwrite_m, pcsrc_m}, {5'b0, p.r, p.m, p.p});
            chk("counters", {exec_cnt, skip_cnt}, {p.e, p.s});
        end
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not end within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        for (int c = 0; c < NCTX; c++) mf[c] = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_m", {5'b0, regwrite_m, memwrite_m, pcsrc_m}, 8'h00);
        chk("rst_cnt", {exec_cnt, skip_cnt}, 8'h00);
        chk("rst_flags", {4'b0, flags_e}, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        // ADDS then BEQ on ctx 0
        cyc(1, 0, 4'b1110, 2'b11, 1, 0, 0, 0, 4'b0100, 0, 0, 0);
        chk("adds_flags", {4'b0, flags_e}, 8'h04);
        cyc(1, 0, 4'b0000, 2'b00, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
        chk("beq_pcsrc", {7'b0, pcsrc_m}, 8'h01);
        // EQ failing on ctx 1
        cyc(1, 1, 4'b0000, 2'b00, 1, 1, 0, 0, 4'b1111, 0, 0, 0);
        chk("eq_fail_m", {6'b0, regwrite_m, memwrite_m}, 8'h00);
        chk("eq_fail_skip", {4'b0, skip_cnt}, 8'h01);
        // group independence on ctx 2
        cyc(1, 2, 4'b1110, 2'b11, 0, 0, 0, 0, 4'b1111, 0, 0, 0);
        cyc(1, 2, 4'b1110, 2'b01, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        chk("grp_cv", {4'b0, flags_e}, 8'h0c);
        cyc(1, 2, 4'b1110, 2'b10, 0, 0, 0, 0, 4'b0011, 0, 0, 0);
        chk("grp_nz", {4'b0, flags_e}, 8'h00);
        // context separation
        cyc(1, 0, 4'b1110, 2'b11, 0, 0, 0, 0, 4'b1000, 0, 0, 0);
        cyc(1, 1, 4'b0100, 2'b00, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        chk("mi_ctx1", {7'b0, condex_e}, 8'h00);
        cyc(1, 0, 4'b0100, 2'b00, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        chk("mi_ctx0", {7'b0, condex_e}, 8'h01);
        // out-of-range context reads zero and never writes
        cyc(1, 3, 4'b1110, 2'b11, 1, 0, 0, 0, 4'b1111, 0, 0, 0);
        cyc(1, 3, 4'b0000, 2'b00, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        chk("ctx_oor_z", {7'b0, condex_e}, 8'h00);
        cyc(0, 0, 4'b1110, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        chk("ctx0_kept", {4'b0, flags_e}, 8'h08);
        // stall, stall+flush, flush, never
        cyc(1, 0, 4'b1110, 2'b00, 1, 1, 1, 0, 4'b0000, 0, 0, 0);
        repeat (3) cyc(1, 0, 4'b1110, 2'b11, 0, 0, 0, 0, 4'b0110, 1, 0, 0);
        cyc(1, 0, 4'b1110, 2'b11, 0, 0, 0, 0, 4'b0110, 1, 1, 0);
        chk("stall_hold", {5'b0, regwrite_m, memwrite_m, pcsrc_m}, 8'h07);
        cyc(1, 0, 4'b1110, 2'b11, 1, 1, 1, 1, 4'b0110, 0, 1, 0);
        chk("flush_bubble", {5'b0, regwrite_m, memwrite_m, pcsrc_m}, 8'h00);
        cyc(1, 0, 4'b1111, 2'b11, 1, 1, 1, 1, 4'b0110, 0, 0, 0);
        chk("cond_nv", {7'b0, condex_e}, 8'h00);
        // every condition against every flag value
        for (int f = 0; f < 16; f++) begin
            cyc(1, 2, 4'b1110, 2'b11, 0, 0, 0, 0, 4'(f), 0, 0, 0);
            for (int c = 0; c < 16; c++) cyc(1, 2, 4'(c), 2'b00, 1, 0, 0, 1, 4'b0000, 0, 0, 0);
        end
        // counter clear during stall, then saturation
        cyc(1, 0, 4'b1110, 2'b00, 1, 0, 0, 0, 4'b0000, 1, 0, 1);
        chk("clr_stall", {exec_cnt, skip_cnt}, 8'h00);
        repeat (20) cyc(1, 1, 4'b1110, 2'b00, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        chk("exec_sat", {4'b0, exec_cnt}, 8'h0f);
        // asynchronous reset mid-stream
        valid_e = 1; ctx_e = 0; cond_e = 4'b1110; regw_e = 1; memw_e = 1;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_m", {5'b0, regwrite_m, memwrite_m, pcsrc_m}, 8'h00);
        chk("arst_cnt", {exec_cnt, skip_cnt}, 8'h00);
        chk("arst_flags", {4'b0, flags_e}, 8'h00);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cond_unit_pipe.md
# cond_unit_pipe

Registered, multi-context successor to the control unit's conditional-logic stage. It evaluates the ARM condition field of the Execute-stage instruction against a banked NZCV flag register and updates that register under group write enables. It registers the gated RegWrite/MemWrite/PCSrc into the Memory stage with stall and flush support, and keeps saturating executed/skipped instruction counters. It sits between the Execute-stage decoder outputs and the Memory-stage pipeline register.

## Interface
Parameters:
- NCTX, 1: number of independent NZCV flag contexts (banked modes/threads); ≥1.
- CNT_W, 16: width of each performance counter.
- CW, max(1,$clog2(NCTX)): width of the context select (derived).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- valid_e  in  1  Execute-stage instruction present.
- ctx_e  in  CW  flag context used by the E instruction.
- cond_e  in  4  condition field.
- flagw_e  in  2  flag group write request: [1] for N,Z; [0] for C,V.
- regw_e, memw_e, pcs_e, branch_e  in  1 each  ungated decoder enables.
- aluflags_e  in  4  ALU result flags {N,Z,C,V}.
- stall  in  1  freeze this stage.
- flush_e  in  1  kill the E instruction.
- clr_cnt  in  1  synchronous counter clear.
- condex_e  out  1  condition passed; combinational.
- flags_e  out  4  current stored flags of ctx_e; combinational.
- regwrite_m, memwrite_m, pcsrc_m  out  1 each  registered gated enables.
- exec_cnt, skip_cnt  out  CNT_W each  performance counters.

## Operation
- live = valid_e & ~flush_e & ~stall.
- condex_e decodes cond_e against the stored flags[ctx_e], before any update by the current instruction:
  - EQ/NE: Z/~Z. CS/CC: C/~C. MI/PL: N/~N. VS/VC: V/~V.
  - HI: C&~Z. LS: ~(C&~Z). GE: N==V. LT: N!=V. GT: ~Z&(N==V). LE: ~(~Z&(N==V)).
  - 1110: always 1. 1111: 0 (never); never X.
- Flag update on clock edge when live & condex_e:
  - flagw_e[1] loads flags[ctx_e][3:2] from aluflags_e[3:2].
  - flagw_e[0] loads flags[ctx_e][1:0] from aluflags_e[1:0].
  - The two groups are independent. Other contexts are never touched.
- M register on clock edge:
  - When stall=1, the M register holds.
  - Otherwise regwrite_m = live&condex_e&regw_e, memwrite_m = live&condex_e&memw_e, pcsrc_m = live&condex_e&(pcs_e|branch_e).
  - A flushed or invalid E slot loads all zeros (bubble).
- Counters:
  - When clr_cnt=1, both counters go to 0. clr_cnt has priority and acts even during stall.
  - Otherwise, on live: exec_cnt += condex_e and skip_cnt += ~condex_e.
  - Counters saturate at 2^CNT_W−1; no wrap.
- ctx_e ≥ NCTX: condex_e is evaluated against all-zero flags, and no flag write occurs.

## Timing
- Reset (reset=0, asynchronous): every flags[c] is 0000, regwrite_m/memwrite_m/pcsrc_m are 0, and exec_cnt/skip_cnt are 0. Takes effect immediately, mid-operation included.
- condex_e and flags_e: zero-cycle, combinational from ctx_e/cond_e and the flag register.
- Gated enables: 1-cycle latency E→M.
- Flag write from the instruction in cycle t is visible to the instruction in cycle t+1 (same ctx), with no bubble. There is no same-cycle bypass.
- Stall: the flag register, M register and counters all hold. condex_e stays valid combinationally.
- stall together with flush_e: stall wins, so nothing changes. The flush must be reasserted when the stall drops.

## Test plan
- Reset, then valid ADDS (cond=1110, flagw=11, aluflags=0100) → condex_e=1, and the next cycle flags_e=0100. A following BEQ (cond=0000, branch_e=1) gives pcsrc_m=1 one cycle after it.
- Flags=0000, cond=0000 with regw=1, memw=1 → condex_e=0, regwrite_m=memwrite_m=0, flags unchanged, skip_cnt 0→1.
- Group independence: flags=1111, flagw=01, aluflags=0000 → flags=1100. Then flagw=10, aluflags=0011 → flags=0000.
- NCTX=2: write flags 1000 in ctx 0, then cond=0100 (MI) on ctx 1 → condex_e=0. The same condition on ctx 0 → condex_e=1.
- Stall held 3 cycles with a live-looking E instruction → M outputs, flags and counters are unchanged. flush_e with stall=0 → bubble with all M outputs 0. Cond=1111 → condex_e=0.
- CNT_W=4: 20 consecutive passing instructions → exec_cnt saturates at 15. clr_cnt during stall → both counters 0. Reset asserted mid-stream → all outputs 0 at once.
